// File: rtl/peak_scan_controller.sv
// Ramps the DAC, detects a debounced zero-crossing of the SG gradient and parks at the peak.
// Optional `SCAN_DECIM_EN: the ramp advances once every 2^DECIM_LOG2 cycles.
module peak_scan_controller #(
  parameter int DAC_WIDTH  = 14,
  parameter int DEBOUNCE   = 4,
  parameter int DECIM_LOG2 = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 diff_state_in,
  input  logic [DAC_WIDTH-1:0] ramp_min,
  input  logic [DAC_WIDTH-1:0] ramp_max,
  input  logic [DAC_WIDTH-1:0] ramp_step,
  output logic [DAC_WIDTH-1:0] dac_out,
  output logic [DAC_WIDTH-1:0] peak_pos,
  output logic                 peak_valid,
  output logic                 busy,
  output logic                 locked,
  output logic                 fault
);

  // state   | meaning
  // IDLE    | waiting for start, outputs static
  // SWEEP   | ramping, looking for a rising edge on diff_state_in
  // CONFIRM | candidate latched, debouncing the high level
  // HOLD    | parked at the confirmed peak
  // FAULT   | bad config or ramp reached max without a peak
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SWEEP   = 3'd1,
    CONFIRM = 3'd2,
    HOLD    = 3'd3,
    FAULT   = 3'd4
  } state_t;

  localparam logic [7:0] DEB_C = 8'(DEBOUNCE);

  if (DEBOUNCE < 1 || DEBOUNCE > 255 || DECIM_LOG2 < 1) begin : g_param_check
    $error("peak_scan_controller: DEBOUNCE must be 1..255 and DECIM_LOG2 >= 1");
  end

  state_t               state_q, state_d;
  logic [DAC_WIDTH-1:0] dac_q, dac_d;
  logic [DAC_WIDTH-1:0] peak_q, peak_d;
  logic                 pv_q, pv_d;
  logic [DAC_WIDTH-1:0] max_q, max_d;
  logic [DAC_WIDTH-1:0] step_q, step_d;
  logic [DAC_WIDTH-1:0] cand_q, cand_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 prev_q, prev_d;

  logic [DAC_WIDTH:0]   sum;
  logic [DAC_WIDTH-1:0] ramp_next;
  logic [DAC_WIDTH-1:0] ramp_adv;
  logic [7:0]           cnt_inc;
  logic                 at_max;
  logic                 step_en;

`ifdef SCAN_DECIM_EN
  logic [DECIM_LOG2-1:0] presc_q, presc_d;
  assign step_en = &presc_q;
`else
  assign step_en = 1'b1;
`endif

  // Sum is one bit wider than the code so saturation never sees a wrapped value.
  assign sum       = {1'b0, dac_q} + {1'b0, step_q};
  assign ramp_next = (sum > {1'b0, max_q}) ? max_q : sum[DAC_WIDTH-1:0];
  assign ramp_adv  = step_en ? ramp_next : dac_q;
  assign at_max    = (dac_q == max_q);
  assign cnt_inc   = cnt_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dac_q   <= '0;
      peak_q  <= '0;
      pv_q    <= 1'b0;
      max_q   <= '0;
      step_q  <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
`ifdef SCAN_DECIM_EN
      presc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      dac_q   <= dac_d;
      peak_q  <= peak_d;
      pv_q    <= pv_d;
      max_q   <= max_d;
      step_q  <= step_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
`ifdef SCAN_DECIM_EN
      presc_q <= presc_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    dac_d   = dac_q;
    peak_d  = peak_q;
    pv_d    = 1'b0;
    max_d   = max_q;
    step_d  = step_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    prev_d  = diff_state_in;
`ifdef SCAN_DECIM_EN
    presc_d = (state_q == SWEEP || state_q == CONFIRM) ? presc_q + 1'b1 : presc_q;
`endif
    if (abort) begin
      state_d = IDLE;
    end else if (start) begin
      max_d   = ramp_max;
      step_d  = ramp_step;
      dac_d   = ramp_min;
      cnt_d   = '0;
`ifdef SCAN_DECIM_EN
      presc_d = '0;
`endif
      state_d = (ramp_min >= ramp_max || ramp_step == '0) ? FAULT : SWEEP;
    end else begin
      case (state_q)
        SWEEP: begin
          // An edge wins over reaching max in the same cycle.
          if (diff_state_in && !prev_q) begin
            cand_d = dac_q;
            cnt_d  = 8'd1;
            if (DEB_C == 8'd1) begin
              peak_d  = dac_q;
              pv_d    = 1'b1;
              state_d = HOLD;
            end else begin
              dac_d   = ramp_adv;
              state_d = CONFIRM;
            end
          end else if (step_en && at_max) begin
            state_d = FAULT;
          end else begin
            dac_d = ramp_adv;
          end
        end
        CONFIRM: begin
          if (!diff_state_in) begin
            if (step_en && at_max) begin
              state_d = FAULT;
            end else begin
              dac_d   = ramp_adv;
              state_d = SWEEP;
            end
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_C) begin
              peak_d  = cand_q;
              pv_d    = 1'b1;
              dac_d   = cand_q;
              state_d = HOLD;
            end else begin
              dac_d = ramp_adv;
            end
          end
        end
        HOLD:    dac_d = peak_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy   = 1'b0;
    locked = 1'b0;
    fault  = 1'b0;
    case (state_q)
      SWEEP, CONFIRM: busy   = 1'b1;
      HOLD:           locked = 1'b1;
      FAULT:          fault  = 1'b1;
      default: ;
    endcase
  end

  assign dac_out    = dac_q;
  assign peak_pos   = peak_q;
  assign peak_valid = pv_q;

endmodule

// File: tb/tb_peak_scan_controller.sv
// Bench for peak_scan_controller: directed scenarios plus random scans against a scan-level model.
// Build with +define+SCAN_DECIM_EN to exercise the decimated ramp.
module tb_peak_scan_controller;
  localparam int W     = 14;
  localparam int DEB   = 4;
  localparam int DL    = 3;
  localparam int PAT_N = 4096;
`ifdef SCAN_DECIM_EN
  localparam int SHIFT = DL;
`else
  localparam int SHIFT = 0;
`endif

  logic         clk = 1'b0;
  logic         rst, start, abort, diff;
  logic [W-1:0] rmin, rmax, rstep;
  logic [W-1:0] dac_out, peak_pos;
  logic         peak_valid, busy, locked, fault;

  int n_chk = 0;
  int n_err = 0;
  bit pat [PAT_N];
  int cfg_min, cfg_max, cfg_step;
  bit pre;
  int last_peak = 0;

  always #4 clk = ~clk;

  peak_scan_controller #(.DAC_WIDTH(W), .DEBOUNCE(DEB), .DECIM_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .diff_state_in(diff),
    .ramp_min(rmin), .ramp_max(rmax), .ramp_step(rstep),
    .dac_out(dac_out), .peak_pos(peak_pos), .peak_valid(peak_valid),
    .busy(busy), .locked(locked), .fault(fault)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Ramp code seen on dac_out k cycles after the start cycle.
  function automatic int ramp(input int k);
    int v;
    v = cfg_min + (k >> SHIFT) * cfg_step;
    return (v > cfg_max) ? cfg_max : v;
  endfunction

  function automatic bit step_cycle(input int k);
    return ((k + 1) % (1 << SHIFT)) == 0;
  endfunction

  function automatic int k_at(input int mn, input int st, input int val);
    return ((val - mn) / st) << SHIFT;
  endfunction

  // Scan-level prediction: walks the diff pattern, not the controller's states.
  task automatic predict(output int kev, output bit is_peak, output int pk);
    int k, run;
    bit prv;
    k = 0; kev = -1; is_peak = 0; pk = 0;
    while (kev < 0 && k < PAT_N) begin
      prv = (k == 0) ? pre : pat[k-1];
      if (pat[k] && !prv) begin
        run = 0;
        while (k + run < PAT_N && pat[k+run]) run++;
        if (run >= DEB) begin
          kev = k + DEB - 1; is_peak = 1; pk = ramp(k);
        end else if (k + run < PAT_N && step_cycle(k + run) && ramp(k + run) == cfg_max) begin
          kev = k + run;
        end else begin
          k = k + run + 1;
        end
      end else if (step_cycle(k) && ramp(k) == cfg_max) begin
        kev = k;
      end else begin
        k++;
      end
    end
  endtask

  task automatic check_outs(input string nm, input int e_dac, input int e_busy, input int e_lock,
                            input int e_fault, input int e_pv, input int e_peak);
    check_eq({nm, ".dac"},    int'(dac_out),    e_dac);
    check_eq({nm, ".busy"},   int'(busy),       e_busy);
    check_eq({nm, ".locked"}, int'(locked),     e_lock);
    check_eq({nm, ".fault"},  int'(fault),      e_fault);
    check_eq({nm, ".pvalid"}, int'(peak_valid), e_pv);
    check_eq({nm, ".peak"},   int'(peak_pos),   e_peak);
  endtask

  task automatic clear_pat();
    for (int i = 0; i < PAT_N; i++) pat[i] = 0;
  endtask

  task automatic set_ones(input int a, input int b);
    for (int i = a; i <= b && i < PAT_N; i++) pat[i] = 1;
  endtask

  task automatic run_scan(input int mn, input int mx, input int st, input bit p, input string nm);
    int kev, pk;
    bit is_peak;
    cfg_min = mn; cfg_max = mx; cfg_step = st; pre = p;
    predict(kev, is_peak, pk);
    if (kev < 0) kev = PAT_N - 8;
    @(negedge clk);
    rmin = W'(mn); rmax = W'(mx); rstep = W'(st); diff = p; start = 1;
    @(negedge clk);
    start = 0;
    for (int k = -1; k <= kev + 3; k++) begin
      if (k < kev)
        check_outs(nm, ramp(k + 1), 1, 0, 0, 0, last_peak);
      else if (is_peak)
        check_outs(nm, pk, 0, 1, 0, (k == kev) ? 1 : 0, pk);
      else
        check_outs(nm, cfg_max, 0, 0, 1, 0, last_peak);
      diff = (k + 1 < PAT_N) ? pat[k+1] : 1'b0;
      @(negedge clk);
    end
    if (is_peak) last_peak = pk;
    diff = 0;
  endtask

  initial begin
    #(8 * 95000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; start = 0; abort = 0; diff = 0; rmin = '0; rmax = '0; rstep = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    for (int c = 0; c < 100; c++) begin
      if (c % 10 == 0) check_outs("reset", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
    end

    // Ramp to max with no crossing, then restart and find peaks.
    clear_pat();
    run_scan(100, 1000, 10, 0, "nopeak");

    clear_pat();
    set_ones(k_at(100, 10, 300), PAT_N - 1);
    run_scan(100, 1000, 10, 0, "peak300");
    check_eq("peak300.value", last_peak, 300);

    clear_pat();
    set_ones(k_at(100, 10, 300), k_at(100, 10, 300) + 1);
    set_ones(k_at(100, 10, 500), PAT_N - 1);
    run_scan(100, 1000, 10, 0, "glitch");
    check_eq("glitch.value", last_peak, 500);

    clear_pat();
    set_ones(0, 9);
    set_ones(15, PAT_N - 1);
    run_scan(100, 1000, 10, 1, "prehigh");

    // Configuration errors
    @(negedge clk);
    rmin = 500; rmax = 500; rstep = 10; start = 1;
    @(negedge clk);
    start = 0;
    check_outs("minmax", 500, 0, 0, 1, 0, last_peak);
    rmin = 100; rmax = 1000; rstep = 0; start = 1;
    @(negedge clk);
    start = 0;
    check_outs("step0", 100, 0, 0, 1, 0, last_peak);

    // Abort mid-sweep
    rstep = 10; diff = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (k_at(100, 10, 400)) @(negedge clk);
    check_outs("presabort", 400, 1, 0, 0, 0, last_peak);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check_outs("abort", 400, 0, 0, 0, 0, last_peak);
    repeat (3) @(negedge clk);
    check_outs("idlehold", 400, 0, 0, 0, 0, last_peak);

    rmin = 200; start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    check_outs("startabort", 400, 0, 0, 0, 0, last_peak);

    // Random scans
    for (int n = 0; n < 20; n++) begin
      int mn, span, st, k, len;
      bit hi;
      mn   = $urandom_range(0, 8000);
      span = $urandom_range(1, 8000);
      if ($urandom_range(0, 3) == 0) st = $urandom_range(span, span + 100);
      else st = $urandom_range(span / 300 + 1, span / 300 + 300);
      clear_pat();
      if ($urandom_range(0, 4) != 0) begin
        k = 0;
        hi = 1'($urandom_range(0, 1));
        while (k < PAT_N) begin
          len = hi ? $urandom_range(1, 7) : $urandom_range(1, 40);
          for (int j = 0; j < len && k < PAT_N; j++) begin
            pat[k] = hi;
            k++;
          end
          hi = !hi;
        end
      end
      run_scan(mn, mn + span, st, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/peak_scan_controller.md
Name: peak_scan_controller

Overview:
- Sequences a DAC ramp scan and uses the zero-crossing discriminator output (`diff_state`, high when the SG gradient is ≤ 0) to find a transmission/error-signal peak.
- Debounces the detected crossing, latches the ramp position, then parks the DAC at the peak and flags it as locked.
- Sits between the PS configuration registers and the fast DAC path, next to the CIC + SG differentiator chain. All logic is on the 125 MHz ADC clock.

Parameters:
- DAC_WIDTH, 14, width of ramp/DAC codes (unsigned offset binary).
- DEBOUNCE, 4, consecutive cycles `diff_state_in` must stay high to confirm a peak (1..255).
- DECIM_LOG2, 3, log2 of the cycles per ramp step; used only with SCAN_DECIM_EN.

Ports:
- clk  in  1  system clock, 125 MHz.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse: begin or restart a scan.
- abort  in  1  single-cycle pulse: return to IDLE.
- diff_state_in  in  1  differentiator discriminator output, same clock domain, no synchroniser.
- ramp_min  in  DAC_WIDTH  scan start code; sampled on start.
- ramp_max  in  DAC_WIDTH  scan end code; sampled on start.
- ramp_step  in  DAC_WIDTH  increment per step; sampled on start.
- dac_out  out  DAC_WIDTH  ramp/park code (registered).
- peak_pos  out  DAC_WIDTH  last confirmed peak code.
- peak_valid  out  1  one-cycle pulse when peak_pos updates.
- busy  out  1  high in SWEEP or CONFIRM.
- locked  out  1  high in HOLD.
- fault  out  1  high in FAULT.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - dac_out = 0, peak_pos = 0.
  - peak_valid = busy = locked = fault = 0.
  - Internal config copies = 0, debounce counter = 0, prev_diff = 0.
- All outputs are registered; state flags decode from the state register.
- Priority each cycle: abort > start > normal transition. Simultaneous start and abort → IDLE.
- abort from any state → IDLE next cycle. dac_out holds its value; peak_pos is kept.
- start from any state:
  - Latch ramp_min, ramp_max and ramp_step; set dac_out = ramp_min; set prev_diff = diff_state_in.
  - A level that is already high therefore does not count as an edge.
  - If ramp_min ≥ ramp_max or ramp_step = 0 → FAULT; otherwise → SWEEP.
- IDLE: outputs static; waits for start.
- SWEEP:
  - Each step, dac_out ← min(dac_out + step, max). The sum is computed in DAC_WIDTH+1 bits, so there is no wrap-around.
  - Rising edge (prev_diff = 0, diff_state_in = 1):
    - Capture candidate = dac_out as it is this cycle.
    - Set the debounce counter to 1 and go to CONFIRM.
    - The edge takes precedence over reaching max in the same cycle.
  - No edge and dac_out == max → FAULT.
  - prev_diff updates every cycle.
- CONFIRM:
  - The ramp keeps stepping (saturating at max).
  - diff_state_in = 0:
    - If dac_out == max → FAULT.
    - Otherwise discard the candidate and return to SWEEP.
  - diff_state_in = 1: increment the counter.
  - When the counter reaches DEBOUNCE:
    - peak_pos ← candidate; peak_valid = 1 for exactly one cycle.
    - dac_out ← candidate; go to HOLD.
  - DEBOUNCE = 1 confirms on the edge cycle itself: SWEEP → HOLD directly.
- HOLD: dac_out = peak_pos; locked = 1; diff_state_in is ignored.
- FAULT: fault = 1; dac_out holds; only start or abort leave this state.
- Latency:
  - start → first ramp code on dac_out: 1 cycle.
  - Confirming diff sample → peak_valid / locked: 1 cycle.

Optional Feature:
- Macro: SCAN_DECIM_EN.
- Defined:
  - A DECIM_LOG2-bit prescaler is cleared on start.
  - dac_out advances only when the prescaler wraps, i.e. every 2^DECIM_LOG2 cycles.
  - Edge detection and debounce still run every cycle.
  - The max/FAULT check is evaluated only on step cycles.
- Undefined: dac_out steps every cycle in SWEEP/CONFIRM, and DECIM_LOG2 is unused.

Test Plan:
1. Reset released, no start.
   - Expected: dac_out = 0, all flags 0 for 100 cycles.
2. min=100, max=1000, step=10, DEBOUNCE=4. diff_state_in rises when dac_out = 300 and stays high.
   - Expected: busy high from start; peak_valid pulses once 4 cycles after the edge; peak_pos = 300, dac_out = 300, locked = 1.
3. Same config, glitch: diff_state_in high 2 cycles at dac_out = 300, then low; real rise at 500.
   - Expected: no pulse at 300; peak_pos = 500; peak_valid pulses exactly once.
4. min=100, max=1000, step=10, diff_state_in held low.
   - Expected: fault = 1 on the cycle after dac_out = 1000; busy = 0. A later start clears fault and rescans from 100.
5. Configuration and control errors:
   - start with min = max = 500 → FAULT the next cycle, dac_out = 500.
   - start with step = 0 → FAULT.
   - start and abort in the same cycle → IDLE.
   - abort mid-sweep at dac_out = 400 → IDLE with dac_out = 400.
6. diff_state_in already high at start.
   - Expected: no edge detected until it falls and rises again.
   - With SCAN_DECIM_EN and DECIM_LOG2 = 3: dac_out increments every 8 cycles.
